// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one UART transmitter among NUM_REQ requesters; define UART_TX_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin
module uart_tx_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int GAP_CLKS = 2
) (
    input  logic                       i_Clock,
    input  logic                       i_Reset,
    input  logic [NUM_REQ-1:0]         i_Req_DV,
    input  logic [8*NUM_REQ-1:0]       i_Req_Byte,
    output logic [NUM_REQ-1:0]         o_Req_Ack,
    output logic [NUM_REQ-1:0]         o_Req_Done,
    output logic                       o_Tx_DV,
    output logic [7:0]                 o_Tx_Byte,
    input  logic                       i_Tx_Active,
    input  logic                       i_Tx_Done,
    output logic [$clog2(NUM_REQ)-1:0] o_Grant_Idx,
    output logic                       o_Busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int SUM_W = IDX_W + 1;
    localparam logic [SUM_W-1:0] NUM_REQ_S = SUM_W'(NUM_REQ);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} state_t;

    state_t             state_q, state_d;
    logic               tx_dv_q, tx_dv_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [7:0]         gap_q, gap_d;
    logic               done_prev_q, done_prev_d;
    logic               busy_q, busy_d;

    logic [7:0]         req_byte [NUM_REQ];
    logic               req_found;
    logic [IDX_W-1:0]   winner;
    logic [SUM_W-1:0]   cand;
    logic [IDX_W-1:0]   next_ptr;
    logic               done_rise;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign req_byte[g] = i_Req_Byte[8*g +: 8];
    end

    assign done_rise = i_Tx_Done & ~done_prev_q;

    // Fixed priority keeps the search origin pinned at requester 0
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    assign next_ptr = '0;
`else
    assign next_ptr = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
`endif

    // Search upward from the pointer with wrap; first pending requester wins
    always_comb begin
        req_found = 1'b0;
        winner    = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + SUM_W'(i);
            if (cand >= NUM_REQ_S) begin
                cand = cand - NUM_REQ_S;
            end
            if (!req_found && i_Req_DV[cand[IDX_W-1:0]]) begin
                req_found = 1'b1;
                winner    = cand[IDX_W-1:0];
            end
        end
    end

    // Next state and next registered outputs of the arbitration FSM
    always_comb begin
        state_d     = state_q;
        tx_dv_d     = 1'b0;
        tx_byte_d   = tx_byte_q;
        ack_d       = '0;
        done_d      = '0;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        gap_d       = gap_q;
        done_prev_d = i_Tx_Done;
        unique case (state_q)
            IDLE: begin
                if (req_found && !i_Tx_Active) begin
                    tx_byte_d      = req_byte[winner];
                    tx_dv_d        = 1'b1;
                    ack_d[winner]  = 1'b1;
                    grant_d        = winner;
                    state_d        = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done_rise) begin
                    done_d[grant_q] = 1'b1;
                    ptr_d           = next_ptr;
                    gap_d           = 8'(GAP_CLKS);
                    state_d         = GAP;
                end
            end
            GAP: begin
                if (gap_q != 8'd0) begin
                    gap_d = gap_q - 8'd1;
                end else if (!i_Tx_Done && !i_Tx_Active) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers, cleared asynchronously by reset
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q     <= IDLE;
            tx_dv_q     <= 1'b0;
            tx_byte_q   <= 8'd0;
            ack_q       <= '0;
            done_q      <= '0;
            grant_q     <= '0;
            ptr_q       <= '0;
            gap_q       <= 8'd0;
            done_prev_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_dv_q     <= tx_dv_d;
            tx_byte_q   <= tx_byte_d;
            ack_q       <= ack_d;
            done_q      <= done_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            gap_q       <= gap_d;
            done_prev_q <= done_prev_d;
            busy_q      <= busy_d;
        end
    end

    assign o_Req_Ack   = ack_q;
    assign o_Req_Done  = done_q;
    assign o_Tx_DV     = tx_dv_q;
    assign o_Tx_Byte   = tx_byte_q;
    assign o_Grant_Idx = grant_q;
    assign o_Busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized bench for uart_tx_arbiter against a frame-level reference model
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int GAP = 2;

    logic           i_Clock = 1'b0;
    logic           i_Reset;
    logic [N-1:0]   i_Req_DV;
    logic [8*N-1:0] i_Req_Byte;
    logic [N-1:0]   o_Req_Ack;
    logic [N-1:0]   o_Req_Done;
    logic           o_Tx_DV;
    logic [7:0]     o_Tx_Byte;
    logic           i_Tx_Active;
    logic           i_Tx_Done;
    logic [1:0]     o_Grant_Idx;
    logic           o_Busy;

    uart_tx_arbiter #(.NUM_REQ(N), .GAP_CLKS(GAP)) dut (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_Req_DV    (i_Req_DV),
        .i_Req_Byte  (i_Req_Byte),
        .o_Req_Ack   (o_Req_Ack),
        .o_Req_Done  (o_Req_Done),
        .o_Tx_DV     (o_Tx_DV),
        .o_Tx_Byte   (o_Tx_Byte),
        .i_Tx_Active (i_Tx_Active),
        .i_Tx_Done   (i_Tx_Done),
        .o_Grant_Idx (o_Grant_Idx),
        .o_Busy      (o_Busy)
    );

    always #5 i_Clock = ~i_Clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // requester and transmitter stimulus state
    logic [N-1:0] pend;
    logic [7:0]   rbyte [N];
    logic         act, done;
    int           tx_st, tx_cnt;
    int           mode;

    // reference model: a frame is launched, finished by a Done rise, then
    // the transmitter is unavailable for GAP clocks plus a quiet line
    bit         m_free, m_just, m_in_frame;
    int         m_gap_left, m_ptr;
    bit         m_prev_done;
    logic [N-1:0] exp_ack, exp_done;
    logic       exp_dv, exp_busy;
    logic [7:0] exp_byte;
    int         exp_grant;

    int dut_log [$];
    int byte_log [$];
    bit mid_done = 0;

    function automatic int pick(input logic [N-1:0] req, input int p);
        for (int k = 0; k < N; k++) begin
            if (req[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_free = 1; m_just = 0; m_in_frame = 0; m_gap_left = 0; m_ptr = 0; m_prev_done = 0;
        exp_ack = '0; exp_done = '0; exp_dv = 0; exp_busy = 0; exp_byte = 8'h00; exp_grant = 0;
    endtask

    task automatic model_step();
        int w;
        exp_ack = '0; exp_done = '0; exp_dv = 0;
        if (m_free) begin
            if (pend != '0 && !act) begin
                w = pick(pend, m_ptr);
                exp_ack[w] = 1'b1;
                exp_dv     = 1;
                exp_byte   = rbyte[w];
                exp_grant  = w;
                m_free     = 0;
                m_just     = 1;
            end
        end else if (m_just) begin
            m_just = 0;
            m_in_frame = 1;
        end else if (m_in_frame) begin
            if (done && !m_prev_done) begin
                exp_done[exp_grant] = 1'b1;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
                m_ptr = (exp_grant + 1) % N;
`endif
                m_in_frame = 0;
                m_gap_left = GAP;
            end
        end else begin
            if (m_gap_left > 0) m_gap_left--;
            else if (!done && !act) m_free = 1;
        end
        m_prev_done = done;
        exp_busy = !m_free;
    endtask

    task automatic drive();
        i_Req_DV    = pend;
        i_Req_Byte  = {rbyte[3], rbyte[2], rbyte[1], rbyte[0]};
        i_Tx_Active = act;
        i_Tx_Done   = done;
    endtask

    task automatic update_stim(input int cyc);
        for (int k = 0; k < N; k++) begin
            if (exp_ack[k]) pend[k] = 1'b0;
            if (mode == 0) begin
                if (cyc == 3 && k == 2) begin pend[k] = 1'b1; rbyte[k] = 8'hA5; end
            end else if (mode == 1) begin
                if (!pend[k]) begin pend[k] = 1'b1; rbyte[k] = 8'h10 + 8'(k); end
            end else begin
                if (pend[k] && $urandom_range(0, 15) == 0) pend[k] = 1'b0;
                else if (!pend[k] && $urandom_range(0, 3) == 0) begin
                    pend[k] = 1'b1; rbyte[k] = 8'($urandom);
                end
            end
        end
        if (exp_dv) begin
            tx_st = 1; tx_cnt = $urandom_range(1, 4); act = 1; done = 0;
        end else begin
            case (tx_st)
                1: begin
                    tx_cnt--;
                    if (tx_cnt == 0) begin tx_st = 2; tx_cnt = $urandom_range(1, 3); act = 0; done = 1; end
                end
                2: begin
                    tx_cnt--;
                    if (tx_cnt == 0) begin tx_st = 0; done = 0; end
                end
                default: begin
                    done = 0;
                    act  = (mode == 2) && ($urandom_range(0, 7) == 0);
                end
            endcase
        end
        drive();
    endtask

    task automatic check_outputs();
        chk("ack",     32'(o_Req_Ack),   32'(exp_ack));
        chk("done",    32'(o_Req_Done),  32'(exp_done));
        chk("tx_dv",   32'(o_Tx_DV),     32'(exp_dv));
        chk("tx_byte", 32'(o_Tx_Byte),   32'(exp_byte));
        chk("grant",   32'(o_Grant_Idx), 32'(exp_grant));
        chk("busy",    32'(o_Busy),      32'(exp_busy));
        if (o_Tx_DV === 1'b1) begin
            dut_log.push_back(int'(o_Grant_Idx));
            byte_log.push_back(int'(o_Tx_Byte));
        end
    endtask

    // reset asserted between edges; outputs must clear without a clock
    task automatic do_reset(input bit clear_reqs);
        #2 i_Reset = 1'b1;
        #1 chk("rst_async", {o_Req_Ack, o_Req_Done, o_Tx_DV, o_Tx_Byte, o_Grant_Idx, o_Busy}, 32'd0);
        model_reset();
        i_Tx_Done = 1'b1;
        i_Tx_Active = 1'b1;
        @(negedge i_Clock);
        chk("rst_hold", {o_Req_Ack, o_Req_Done, o_Tx_DV, o_Tx_Byte, o_Grant_Idx, o_Busy}, 32'd0);
        @(negedge i_Clock);
        chk("rst_hold", {o_Req_Ack, o_Req_Done, o_Tx_DV, o_Tx_Byte, o_Grant_Idx, o_Busy}, 32'd0);
        i_Reset = 1'b0;
        if (clear_reqs) pend = '0;
        act = 0; done = 1; tx_st = 2; tx_cnt = 2;
        dut_log.delete();
        byte_log.delete();
    endtask

    int exp_order [5];

    initial begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        pend = '0; act = 0; done = 0; tx_st = 0; tx_cnt = 0; mode = 0;
        for (int k = 0; k < N; k++) rbyte[k] = 8'h00;
        i_Reset = 1'b1;
        drive();
        repeat (2) @(posedge i_Clock);
        @(negedge i_Clock);
        chk("reset_state", {o_Req_Ack, o_Req_Done, o_Tx_DV, o_Tx_Byte, o_Grant_Idx, o_Busy}, 32'd0);
        i_Reset = 1'b0;
        model_reset();

        for (int cyc = 0; cyc < 3000; cyc++) begin
            update_stim(cyc);
            model_step();
            @(negedge i_Clock);
            check_outputs();
            if (cyc == 59) begin
                chk("single_count", dut_log.size(), 1);
                if (dut_log.size() > 0) begin
                    chk("single_grant", dut_log[0], 2);
                    chk("single_byte", byte_log[0], 32'hA5);
                end
                do_reset(1);
                mode = 1;
            end else if (cyc == 259) begin
                chk("contend_count", dut_log.size() >= 5, 1);
                for (int i = 0; i < 5 && i < dut_log.size(); i++) begin
                    chk("contend_order", dut_log[i], exp_order[i]);
                    chk("contend_byte", byte_log[i], 32'h10 + exp_order[i]);
                end
                do_reset(1);
                mode = 2;
            end else if (!mid_done && cyc >= 1500 && m_in_frame) begin
                mid_done = 1;
                do_reset(0);
            end
        end
        chk("mid_reset_seen", mid_done, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
